// File: rtl/video_pkg.sv
// Shared definitions for the pixel-clock video pipeline control blocks.
`timescale 1ns/1ps
package video_pkg;

    localparam int unsigned FRAME_COUNT_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        PRIME     = 2'd2,
        ACTIVE    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer; emits a 1-cycle pulse per accepted press.
`timescale 1ns/1ps
module btn_debounce #(
    parameter int unsigned C_debounce_bits = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic                       btn_meta;
    logic                       btn_sync;
    logic                       level_q;
    logic                       debounced;
    logic [C_debounce_bits-1:0] stable_cnt;
    logic                       settled;

    assign settled = (stable_cnt == '1);
    // level_q is the level that has been stable for stable_cnt cycles
    assign press   = settled & level_q & ~debounced;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta   <= 1'b0;
            btn_sync   <= 1'b0;
            level_q    <= 1'b0;
            debounced  <= 1'b0;
            stable_cnt <= '0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
            level_q  <= btn_sync;
            if (btn_sync != level_q) begin
                stable_cnt <= '0;
            end else if (!settled) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
            if (settled) begin
                debounced <= level_q;
            end
        end
    end

endmodule

// File: rtl/dvi_video_sequencer.sv
// Start-up and mode sequencer: PLL lock qualification, blank priming frames,
// and frame-aligned test-picture toggling for the DVI pipeline.
`timescale 1ns/1ps
module dvi_video_sequencer
    import video_pkg::*;
#(
    parameter int unsigned C_lock_wait     = 1024,
    parameter int unsigned C_blank_frames  = 2,
    parameter int unsigned C_debounce_bits = 16
) (
    input  logic                     clk_pixel,
    input  logic                     reset,
    input  logic                     pll_locked,
    input  logic                     btn_mode,
    input  logic                     vga_vsync,
    output logic                     vga_reset,
    output logic                     force_blank,
    output logic                     test_picture,
    output logic [FRAME_COUNT_W-1:0] frame_count,
    output logic [1:0]               state
);

    localparam int unsigned LOCK_W  = $clog2(C_lock_wait);
    localparam int unsigned BLANK_W = $clog2(C_blank_frames + 1);
    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(C_lock_wait - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(C_blank_frames - 1);

    seq_state_t         cur;
    seq_state_t         nxt;
    logic               lock_meta;
    logic               lock;
    logic               vsync_q;
    logic               fs;
    logic               press;
    logic               pending;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [BLANK_W-1:0] blank_cnt;

    btn_debounce #(
        .C_debounce_bits(C_debounce_bits)
    ) u_btn_debounce (
        .clk  (clk_pixel),
        .reset(reset),
        .btn  (btn_mode),
        .press(press)
    );

    assign fs          = vga_vsync & ~vsync_q & ~vga_reset;
    assign vga_reset   = (cur == WAIT_LOCK) || (cur == STABLE);
    assign force_blank = (cur != ACTIVE);
    assign state       = cur;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            cur <= WAIT_LOCK;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        if (!lock) begin
            nxt = WAIT_LOCK;
        end else begin
            case (cur)
                WAIT_LOCK: nxt = STABLE;
                STABLE:    if (lock_cnt == LOCK_LAST) nxt = PRIME;
                PRIME:     if (fs && (blank_cnt == BLANK_LAST)) nxt = ACTIVE;
                ACTIVE:    nxt = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            lock_meta    <= 1'b0;
            lock         <= 1'b0;
            vsync_q      <= 1'b0;
            lock_cnt     <= '0;
            blank_cnt    <= '0;
            frame_count  <= '0;
            pending      <= 1'b0;
            test_picture <= 1'b1;
        end else begin
            lock_meta <= pll_locked;
            lock      <= lock_meta;
            vsync_q   <= vga_vsync;

            lock_cnt <= (cur == STABLE) ? lock_cnt + 1'b1 : '0;

            if (cur != PRIME) begin
                blank_cnt <= '0;
            end else if (fs) begin
                blank_cnt <= blank_cnt + 1'b1;
            end

            if (!lock || (cur != ACTIVE)) begin
                frame_count <= '0;
            end else if (fs) begin
                frame_count <= frame_count + 1'b1;
            end

            // Lock loss outranks a frame start; a press coinciding with fs waits for the next one
            if (!lock) begin
                pending <= 1'b0;
            end else if ((cur == ACTIVE) && fs && pending) begin
                test_picture <= ~test_picture;
                pending      <= 1'b0;
            end else if (press) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
